mesi_arbiter: RTL and testbench



---
 rtl/mesi_arbiter_if.sv | 30 +++
 rtl/mesi_arbiter.sv | 86 ++++++++
 tb/tb_mesi_arbiter.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/mesi_arbiter_if.sv
// Bus-request / bus-grant bundle between the four cache controllers, the
// memory controller and the shared-bus arbiter.
interface mesi_arbiter_if;
    logic [3:0] Com_Bus_Req_proc;
    logic [3:0] Com_Bus_Req_snoop;
    logic       Mem_snoop_req;
    logic [3:0] Com_Bus_Gnt_proc;
    logic [3:0] Com_Bus_Gnt_snoop;
    logic       Mem_snoop_gnt;

    // Requesters drive requests and observe grants.
    modport master (
        output Com_Bus_Req_proc,
        output Com_Bus_Req_snoop,
        output Mem_snoop_req,
        input  Com_Bus_Gnt_proc,
        input  Com_Bus_Gnt_snoop,
        input  Mem_snoop_gnt
    );

    // The arbiter observes requests and drives grants.
    modport slave (
        input  Com_Bus_Req_proc,
        input  Com_Bus_Req_snoop,
        input  Mem_snoop_req,
        output Com_Bus_Gnt_proc,
        output Com_Bus_Gnt_snoop,
        output Mem_snoop_gnt
    );
endinterface

// File: rtl/mesi_arbiter.sv
// Shared-bus arbiter for the 4-core MESI subsystem.
// Classes in strict priority: memory snoop > core snoop responses > core
// processor requests. Non-preemptive: an owner keeps the bus while its
// request stays high. Round-robin inside each per-core class, using a
// last-granted pointer that only moves when that class gets a new owner.
// The grant vector is {mem, snoop[3:0], proc[3:0]}, always one-hot or zero,
// and is driven straight from flops so grants never glitch.
module mesi_arbiter (
    input  logic          clk,
    input  logic          rst,
    mesi_arbiter_if.slave bus
);

    logic [8:0] gnt_r;
    logic [8:0] gnt_s;
    logic [8:0] req_s;
    logic [1:0] snoop_ptr_r;
    logic [1:0] snoop_ptr_s;
    logic [1:0] proc_ptr_r;
    logic [1:0] proc_ptr_s;
    logic       owner_holds_s;
    logic [1:0] snoop_pick_s;
    logic [1:0] proc_pick_s;

    // Round-robin pick: the first set request at or after ptr+1, wrapping
    // 3->0. The loop walks from farthest (ptr itself) to nearest (ptr+1) so
    // the nearest set bit is the one left in the result.
    function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
        logic [1:0] idx;
        logic [1:0] pick;
        pick = ptr;
        for (int k = 4; k >= 1; k--) begin
            idx = ptr + k[1:0];
            if (req[idx]) begin
                pick = idx;
            end else begin
                pick = pick;
            end
        end
        return pick;
    endfunction

    assign req_s         = {bus.Mem_snoop_req, bus.Com_Bus_Req_snoop, bus.Com_Bus_Req_proc};
    assign owner_holds_s = |(gnt_r & req_s);
    assign snoop_pick_s  = rr_pick(bus.Com_Bus_Req_snoop, snoop_ptr_r);
    assign proc_pick_s   = rr_pick(bus.Com_Bus_Req_proc, proc_ptr_r);

    // Next grant and pointer: hold the current owner, else pick a new winner.
    always_comb begin
        gnt_s       = 9'd0;
        snoop_ptr_s = snoop_ptr_r;
        proc_ptr_s  = proc_ptr_r;
        if (owner_holds_s) begin
            gnt_s = gnt_r;
        end else if (bus.Mem_snoop_req) begin
            gnt_s[8] = 1'b1;
        end else if (|bus.Com_Bus_Req_snoop) begin
            gnt_s[7:4]  = 4'b0001 << snoop_pick_s;
            snoop_ptr_s = snoop_pick_s;
        end else if (|bus.Com_Bus_Req_proc) begin
            gnt_s[3:0]  = 4'b0001 << proc_pick_s;
            proc_ptr_s  = proc_pick_s;
        end else begin
            gnt_s = 9'd0;
        end
    end

    // Grant and round-robin pointer registers; reset drops every grant at
    // once and points both classes at core 3 so core 0 is preferred first.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gnt_r       <= 9'd0;
            snoop_ptr_r <= 2'd3;
            proc_ptr_r  <= 2'd3;
        end else begin
            gnt_r       <= gnt_s;
            snoop_ptr_r <= snoop_ptr_s;
            proc_ptr_r  <= proc_ptr_s;
        end
    end

    assign bus.Mem_snoop_gnt     = gnt_r[8];
    assign bus.Com_Bus_Gnt_snoop = gnt_r[7:4];
    assign bus.Com_Bus_Gnt_proc  = gnt_r[3:0];

endmodule

// File: tb/tb_mesi_arbiter.sv
// Directed bench for mesi_arbiter. Grants are observed as one 9-bit vector
// {mem, snoop[3:0], proc[3:0]} and compared with hand-computed values.
module tb_mesi_arbiter;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    mesi_arbiter_if bus ();

    mesi_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [8:0] gnt_vec();
        return {bus.Mem_snoop_gnt, bus.Com_Bus_Gnt_snoop, bus.Com_Bus_Gnt_proc};
    endfunction

    task automatic check_val(input string tag, input logic [8:0] observed, input logic [8:0] expected);
        n_cmp++;
        if (observed !== expected) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b", tag, observed, expected);
        end
    endtask

    // Drive requests away from the edge.
    task automatic set_req(input logic mem, input logic [3:0] snoop, input logic [3:0] proc);
        bus.Mem_snoop_req     = mem;
        bus.Com_Bus_Req_snoop = snoop;
        bus.Com_Bus_Req_proc  = proc;
    endtask

    // Advance one rising edge and settle 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full reset, leaving requests cleared and rst high before the next edge.
    task automatic do_reset();
        set_req(1'b0, 4'b0000, 4'b0000);
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        set_req(1'b0, 4'b0000, 4'b0000);
        #2;
        do_reset();
        check_val("reset_idle", gnt_vec(), 9'b0_0000_0000);

        // Single proc request from idle, then release.
        set_req(1'b0, 4'b0000, 4'b0001); step();
        check_val("proc0_grant", gnt_vec(), 9'b0_0000_0001);
        set_req(1'b0, 4'b0000, 4'b0000); step();
        check_val("proc0_release_idle", gnt_vec(), 9'b0_0000_0000);

        // Snoop beats proc; proc follows with zero bubble.
        set_req(1'b0, 4'b0001, 4'b0010); step();
        check_val("snoop_over_proc", gnt_vec(), 9'b0_0001_0000);
        set_req(1'b0, 4'b0000, 4'b0010); step();
        check_val("proc1_after_snoop", gnt_vec(), 9'b0_0000_0010);
        set_req(1'b0, 4'b0000, 4'b0000); step();
        check_val("idle_again", gnt_vec(), 9'b0_0000_0000);

        // Three classes at once: mem, then snoop 1, then proc 2.
        set_req(1'b1, 4'b0010, 4'b0100); step();
        check_val("mem_first", gnt_vec(), 9'b1_0000_0000);
        step();
        check_val("mem_held", gnt_vec(), 9'b1_0000_0000);
        set_req(1'b0, 4'b0010, 4'b0100); step();
        check_val("snoop1_second", gnt_vec(), 9'b0_0010_0000);
        set_req(1'b0, 4'b0000, 4'b0100); step();
        check_val("proc2_third", gnt_vec(), 9'b0_0000_0100);
        set_req(1'b0, 4'b0000, 4'b0000); step();

        // Round-robin with proc pointer at 0: index 1 then index 3.
        do_reset();
        set_req(1'b0, 4'b0000, 4'b0001); step();
        check_val("rr_setup_proc0", gnt_vec(), 9'b0_0000_0001);
        set_req(1'b0, 4'b0000, 4'b1010); step();
        check_val("rr_proc1", gnt_vec(), 9'b0_0000_0010);
        set_req(1'b0, 4'b0000, 4'b1000); step();
        check_val("rr_proc3_no_bubble", gnt_vec(), 9'b0_0000_1000);
        set_req(1'b0, 4'b0000, 4'b0000); step();

        // Everything at once, owners drop in turn.
        do_reset();
        set_req(1'b1, 4'b0101, 4'b1111); step();
        check_val("all_mem", gnt_vec(), 9'b1_0000_0000);
        check_val("all_onehot_mem", 9'($countones(gnt_vec())), 9'd1);
        set_req(1'b0, 4'b0101, 4'b1111); step();
        check_val("all_snoop0", gnt_vec(), 9'b0_0001_0000);
        check_val("all_onehot_s0", 9'($countones(gnt_vec())), 9'd1);
        set_req(1'b0, 4'b0100, 4'b1111); step();
        check_val("all_snoop2", gnt_vec(), 9'b0_0100_0000);
        check_val("all_onehot_s2", 9'($countones(gnt_vec())), 9'd1);
        set_req(1'b0, 4'b0000, 4'b1111); step();
        check_val("all_proc0", gnt_vec(), 9'b0_0000_0001);
        check_val("all_onehot_p0", 9'($countones(gnt_vec())), 9'd1);
        set_req(1'b0, 4'b0000, 4'b1110); step();
        check_val("all_proc1", gnt_vec(), 9'b0_0000_0010);
        check_val("all_onehot_p1", 9'($countones(gnt_vec())), 9'd1);
        set_req(1'b0, 4'b0000, 4'b1100); step();
        check_val("all_proc2", gnt_vec(), 9'b0_0000_0100);
        check_val("all_onehot_p2", 9'($countones(gnt_vec())), 9'd1);
        set_req(1'b0, 4'b0000, 4'b1000); step();
        check_val("all_proc3", gnt_vec(), 9'b0_0000_1000);
        check_val("all_onehot_p3", 9'($countones(gnt_vec())), 9'd1);
        set_req(1'b0, 4'b0000, 4'b0000); step();
        check_val("all_idle", gnt_vec(), 9'b0_0000_0000);

        // No preemption, then asynchronous reset mid-grant.
        do_reset();
        set_req(1'b0, 4'b0000, 4'b0001); step();
        check_val("nopre_proc0", gnt_vec(), 9'b0_0000_0001);
        set_req(1'b1, 4'b0000, 4'b0001); step();
        check_val("nopre_hold", gnt_vec(), 9'b0_0000_0001);
        #2;
        rst = 1'b0;
        #1;
        check_val("async_reset_clear", gnt_vec(), 9'b0_0000_0000);
        step();
        check_val("reset_held_idle", gnt_vec(), 9'b0_0000_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
